mips_mc_ctrl: RTL and testbench

Multicycle main controller for the MIPS core. A Moore state machine decodes the instruction opcode and sequences the shared datapath over 3–5 cycles per instruction: one ALU, one unified memory port, the instruction register and the register file. It produces the 2-bit `aluop` consumed by the ALU decoder, plus all mux selects and write enables, and waits on a memory-ready handshake.

---
 rtl/mips_mc_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
// -----------------------------------------------------------------------------
// mips_mc_ctrl: multicycle main controller for the MIPS core.
//
// A Moore state machine that decodes the opcode and sequences the shared
// datapath (one ALU, one unified memory port, IR, register file) over 3-5
// cycles per instruction. Outputs are decoded from the state register. The
// only inputs that reach the outputs directly are mem_ready (irwrite/pcen in
// FETCH), zero (pcen in the branch states), op (illegal in DECODE) and
// reset_n (forces the write enables low).
//
// Configuration macro: MIPS_MC_BNE_EN adds the BNEEX state and decodes
// op=000101 (bne). Without it, bne is treated as an illegal opcode.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   synchronous active-low reset
//   op[5:0]    in   opcode, instr[31:26] from the instruction register
//   zero       in   ALU zero flag
//   mem_ready  in   memory completes the current access this cycle
//   mem_req    out  memory access request
//   memwrite   out  store strobe (valid with mem_req)
//   irwrite    out  load instruction register
//   pcen       out  PC load enable
//   regwrite   out  register-file write
//   iord       out  memory address select: 0 = PC, 1 = ALUOut
//   alusrca    out  ALU A select: 0 = PC, 1 = register A
//   alusrcb    out  ALU B select: 00 = B, 01 = 4, 10 = sext imm, 11 = imm<<2
//   pcsrc      out  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
//   aluop      out  00 = add, 01 = sub, 10 = use funct
//   regdst     out  1 = rd, 0 = rt
//   memtoreg   out  1 = write-back data from memory
//   illegal    out  one-cycle pulse on an unsupported opcode
//
// Memory handshake: mem_req is held high in FETCH, MEMRD and MEMWR until the
// cycle in which mem_ready=1; that cycle completes the access and the state
// advances on the following edge. mem_ready is ignored while mem_req=0.
// -----------------------------------------------------------------------------
module mips_mc_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       regdst,
  output logic       memtoreg,
  output logic       illegal
);

  // Encoding is fixed so the state can be observed and compared directly.
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    ALUWB   = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
`ifdef MIPS_MC_BNE_EN
    ,BNEEX  = 4'd12
`endif
  } state_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  state_e state_q, state_d;
  logic   illegal_dec;

  // Next-state logic. op is only looked at in DECODE and MEMADR, where the
  // instruction register cannot change (irwrite is only asserted in FETCH).
  always_comb begin
    state_d     = state_q;
    illegal_dec = 1'b0;
    case (state_q)
      FETCH:   if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
`ifdef MIPS_MC_BNE_EN
          OP_BNE:       state_d = BNEEX;
`endif
          default: begin
            state_d     = FETCH;
            illegal_dec = 1'b1;
          end
        endcase
      end
      MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   if (mem_ready) state_d = MEMWB;
      MEMWR:   if (mem_ready) state_d = FETCH;
      RTYPEEX: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    mem_req  = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    pcen     = 1'b0;
    regwrite = 1'b0;
    iord     = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcen    = mem_ready;
      end
      DECODE: begin
        alusrcb = 2'b11;
        illegal = illegal_dec;
      end
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      MEMWR: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        pcen    = zero;
      end
`ifdef MIPS_MC_BNE_EN
      BNEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        pcen    = ~zero;
      end
`endif
      ADDIWB: regwrite = 1'b1;
      JEX: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase

    // During reset the instruction in flight is abandoned: every enable and
    // the illegal pulse are suppressed, and the selects show FETCH values.
    if (!reset_n) begin
      mem_req  = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      pcen     = 1'b0;
      regwrite = 1'b0;
      iord     = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b01;
      pcsrc    = 2'b00;
      aluop    = 2'b00;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      illegal  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= FETCH;
    else          state_q <= state_d;
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_mc_ctrl: directed bench for the multicycle main controller.
// Each cycle drives inputs on the falling edge, then checks the current state
// and the full output word against hand-written expectations from the
// state/output table.
// -----------------------------------------------------------------------------
module tb_mips_mc_ctrl;

  // State encodings as observed on the controller's state register.
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;
  localparam logic [3:0] S_BNEEX   = 4'd12;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  // Output word bit positions.
  localparam int B_MEMREQ   = 15;
  localparam int B_MEMWRITE = 14;
  localparam int B_IRWRITE  = 13;
  localparam int B_PCEN     = 12;
  localparam int B_REGWRITE = 11;
  localparam int B_IORD     = 10;
  localparam int B_ALUSRCA  = 9;
  localparam int B_ALUSRCB  = 7;  // [8:7]
  localparam int B_PCSRC    = 5;  // [6:5]
  localparam int B_ALUOP    = 3;  // [4:3]
  localparam int B_REGDST   = 2;
  localparam int B_MEMTOREG = 1;
  localparam int B_ILLEGAL  = 0;

`ifdef MIPS_MC_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, memwrite, irwrite, pcen, regwrite, iord, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic       regdst, memtoreg, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mips_mc_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .op        (op),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .memwrite  (memwrite),
    .irwrite   (irwrite),
    .pcen      (pcen),
    .regwrite  (regwrite),
    .iord      (iord),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .pcsrc     (pcsrc),
    .aluop     (aluop),
    .regdst    (regdst),
    .memtoreg  (memtoreg),
    .illegal   (illegal)
  );

  wire [15:0] outs = {mem_req, memwrite, irwrite, pcen, regwrite, iord, alusrca,
                      alusrcb, pcsrc, aluop, regdst, memtoreg, illegal};

  // ---------------------------------------------------------------- checking
  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected output word from the state/output table.
  function automatic logic [15:0] exp_outs(input logic [3:0] st, input logic rst_n,
                                           input logic rdy, input logic z,
                                           input logic ill);
    logic [15:0] v;
    v = '0;
    if (!rst_n) begin
      v[B_ALUSRCB +: 2] = 2'b01;
      return v;
    end
    case (st)
      S_FETCH: begin
        v[B_MEMREQ] = 1'b1; v[B_ALUSRCB +: 2] = 2'b01;
        v[B_IRWRITE] = rdy; v[B_PCEN] = rdy;
      end
      S_DECODE:  begin v[B_ALUSRCB +: 2] = 2'b11; v[B_ILLEGAL] = ill; end
      S_MEMADR, S_ADDIEX: begin v[B_ALUSRCA] = 1'b1; v[B_ALUSRCB +: 2] = 2'b10; end
      S_MEMRD:   begin v[B_MEMREQ] = 1'b1; v[B_IORD] = 1'b1; end
      S_MEMWB:   begin v[B_REGWRITE] = 1'b1; v[B_MEMTOREG] = 1'b1; end
      S_MEMWR:   begin v[B_MEMREQ] = 1'b1; v[B_IORD] = 1'b1; v[B_MEMWRITE] = 1'b1; end
      S_RTYPEEX: begin v[B_ALUSRCA] = 1'b1; v[B_ALUOP +: 2] = 2'b10; end
      S_ALUWB:   begin v[B_REGWRITE] = 1'b1; v[B_REGDST] = 1'b1; end
      S_BEQEX: begin
        v[B_ALUSRCA] = 1'b1; v[B_ALUOP +: 2] = 2'b01; v[B_PCSRC +: 2] = 2'b01;
        v[B_PCEN] = z;
      end
      S_BNEEX: begin
        v[B_ALUSRCA] = 1'b1; v[B_ALUOP +: 2] = 2'b01; v[B_PCSRC +: 2] = 2'b01;
        v[B_PCEN] = ~z;
      end
      S_ADDIWB:  v[B_REGWRITE] = 1'b1;
      S_JEX:     begin v[B_PCSRC +: 2] = 2'b10; v[B_PCEN] = 1'b1; end
      default:   v = 'x;
    endcase
    return v;
  endfunction

  // ---------------------------------------------------------------- driver
  // One clock cycle: drive inputs on the falling edge, then check the state
  // the controller is in and its outputs for this cycle.
  task automatic cyc(input string tag, input logic [3:0] exp_st, input logic rst_n,
                     input logic rdy, input logic z, input logic [5:0] o,
                     input logic ill);
    @(negedge clk);
    reset_n   = rst_n;
    mem_ready = rdy;
    zero      = z;
    op        = o;
    #1;
    check_eq({tag, " state"}, 32'(dut.state_q), 32'(exp_st));
    check_eq({tag, " outs"}, 32'(outs), 32'(exp_outs(exp_st, rst_n, rdy, z, ill)));
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    zero      = 1'b0;
    op        = OP_LW;

    // Reset held for two edges with mem_ready=1 and a lw opcode present.
    cyc("rst0", S_FETCH, 1'b0, 1'b1, 1'b0, OP_LW, 1'b0);
    cyc("rst1", S_FETCH, 1'b0, 1'b1, 1'b0, OP_LW, 1'b0);

    // lw, zero wait states: 5 cycles.
    cyc("lw fetch",  S_FETCH,  1'b1, 1'b1, 1'b0, OP_LW, 1'b0);
    cyc("lw decode", S_DECODE, 1'b1, 1'b1, 1'b0, OP_LW, 1'b0);
    cyc("lw memadr", S_MEMADR, 1'b1, 1'b1, 1'b0, OP_LW, 1'b0);
    cyc("lw memrd",  S_MEMRD,  1'b1, 1'b1, 1'b0, OP_LW, 1'b0);
    cyc("lw memwb",  S_MEMWB,  1'b1, 1'b1, 1'b0, OP_LW, 1'b0);

    // sw with one fetch wait and three MEMWR wait cycles.
    cyc("sw fetch wait", S_FETCH,  1'b1, 1'b0, 1'b0, OP_SW, 1'b0);
    cyc("sw fetch",      S_FETCH,  1'b1, 1'b1, 1'b0, OP_SW, 1'b0);
    cyc("sw decode",     S_DECODE, 1'b1, 1'b1, 1'b0, OP_SW, 1'b0);
    cyc("sw memadr",     S_MEMADR, 1'b1, 1'b1, 1'b0, OP_SW, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc("sw memwr wait", S_MEMWR, 1'b1, 1'b0, 1'b0, OP_SW, 1'b0);
    cyc("sw memwr done", S_MEMWR,  1'b1, 1'b1, 1'b0, OP_SW, 1'b0);

    // lw with a MEMRD wait cycle.
    cyc("lw2 fetch",    S_FETCH,  1'b1, 1'b1, 1'b0, OP_LW, 1'b0);
    cyc("lw2 decode",   S_DECODE, 1'b1, 1'b1, 1'b0, OP_LW, 1'b0);
    cyc("lw2 memadr",   S_MEMADR, 1'b1, 1'b1, 1'b0, OP_LW, 1'b0);
    cyc("lw2 memrd w",  S_MEMRD,  1'b1, 1'b0, 1'b0, OP_LW, 1'b0);
    cyc("lw2 memrd",    S_MEMRD,  1'b1, 1'b1, 1'b0, OP_LW, 1'b0);
    cyc("lw2 memwb",    S_MEMWB,  1'b1, 1'b1, 1'b0, OP_LW, 1'b0);

    // R-type: 4 cycles.
    cyc("r fetch",  S_FETCH,   1'b1, 1'b1, 1'b0, OP_RTYPE, 1'b0);
    cyc("r decode", S_DECODE,  1'b1, 1'b1, 1'b0, OP_RTYPE, 1'b0);
    cyc("r ex",     S_RTYPEEX, 1'b1, 1'b1, 1'b0, OP_RTYPE, 1'b0);
    cyc("r wb",     S_ALUWB,   1'b1, 1'b1, 1'b0, OP_RTYPE, 1'b0);

    // addi: 4 cycles.
    cyc("addi fetch",  S_FETCH,  1'b1, 1'b1, 1'b0, OP_ADDI, 1'b0);
    cyc("addi decode", S_DECODE, 1'b1, 1'b1, 1'b0, OP_ADDI, 1'b0);
    cyc("addi ex",     S_ADDIEX, 1'b1, 1'b1, 1'b0, OP_ADDI, 1'b0);
    cyc("addi wb",     S_ADDIWB, 1'b1, 1'b1, 1'b0, OP_ADDI, 1'b0);

    // j: 3 cycles.
    cyc("j fetch",  S_FETCH,  1'b1, 1'b1, 1'b0, OP_J, 1'b0);
    cyc("j decode", S_DECODE, 1'b1, 1'b1, 1'b0, OP_J, 1'b0);
    cyc("j ex",     S_JEX,    1'b1, 1'b1, 1'b0, OP_J, 1'b0);

    // beq taken then not taken.
    cyc("beq1 fetch",  S_FETCH,  1'b1, 1'b1, 1'b0, OP_BEQ, 1'b0);
    cyc("beq1 decode", S_DECODE, 1'b1, 1'b1, 1'b0, OP_BEQ, 1'b0);
    cyc("beq1 ex",     S_BEQEX,  1'b1, 1'b1, 1'b1, OP_BEQ, 1'b0);
    cyc("beq0 fetch",  S_FETCH,  1'b1, 1'b1, 1'b0, OP_BEQ, 1'b0);
    cyc("beq0 decode", S_DECODE, 1'b1, 1'b1, 1'b0, OP_BEQ, 1'b0);
    cyc("beq0 ex",     S_BEQEX,  1'b1, 1'b1, 1'b0, OP_BEQ, 1'b0);

    // bne opcode: branch state when enabled, illegal otherwise.
    cyc("bne fetch",  S_FETCH,  1'b1, 1'b1, 1'b0, OP_BNE, 1'b0);
    cyc("bne decode", S_DECODE, 1'b1, 1'b1, 1'b0, OP_BNE, ~BNE_EN);
    if (BNE_EN) begin
      cyc("bne ex", S_BNEEX, 1'b1, 1'b1, 1'b0, OP_BNE, 1'b0);
      cyc("bne2 fetch",  S_FETCH,  1'b1, 1'b1, 1'b0, OP_BNE, 1'b0);
      cyc("bne2 decode", S_DECODE, 1'b1, 1'b1, 1'b0, OP_BNE, 1'b0);
      cyc("bne2 ex",     S_BNEEX,  1'b1, 1'b1, 1'b1, OP_BNE, 1'b0);
    end

    // Unsupported opcode: 2 cycles, illegal only in DECODE.
    cyc("bad fetch",  S_FETCH,  1'b1, 1'b1, 1'b0, OP_BAD, 1'b0);
    cyc("bad decode", S_DECODE, 1'b1, 1'b1, 1'b0, OP_BAD, 1'b1);

    // R-type abandoned by reset in RTYPEEX: no regwrite, back to FETCH.
    cyc("rr fetch",  S_FETCH,   1'b1, 1'b1, 1'b0, OP_RTYPE, 1'b0);
    cyc("rr decode", S_DECODE,  1'b1, 1'b1, 1'b0, OP_RTYPE, 1'b0);
    cyc("rr ex rst", S_RTYPEEX, 1'b0, 1'b1, 1'b0, OP_RTYPE, 1'b0);
    cyc("rr after",  S_FETCH,   1'b1, 1'b1, 1'b0, OP_RTYPE, 1'b0);

    // Reset during a pending MEMRD wait also abandons the access.
    cyc("mw decode", S_DECODE, 1'b1, 1'b1, 1'b0, OP_LW, 1'b0);
    cyc("mw memadr", S_MEMADR, 1'b1, 1'b1, 1'b0, OP_LW, 1'b0);
    cyc("mw memrd w", S_MEMRD, 1'b1, 1'b0, 1'b0, OP_LW, 1'b0);
    cyc("mw rst",     S_MEMRD, 1'b0, 1'b1, 1'b0, OP_LW, 1'b0);
    cyc("mw after",   S_FETCH, 1'b1, 1'b1, 1'b0, OP_LW, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
